// File: rtl/ped_pkg.sv
// ped_pkg: shared FSM state type, lamp encodings and lamp legality check for the crosswalk controller
package ped_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    WALK  = 3'd2,
    FLASH = 3'd3,
    FAULT = 3'd4
  } ped_state_t;
  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;
  // At most one lamp lit; the all-off case is timed separately by the caller.
  function automatic logic legal_lamp(input logic [2:0] l);
    return l inside {3'b000, LAMP_R, LAMP_Y, LAMP_G};
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer, level debounce and one-cycle press pulse on the debounced rising edge
// Ports: clk, reset (sync, active-low), btn_raw (async bouncy input), press (1-cycle pulse per accepted press)
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [1:0] sync_q;
  logic lvl_q, lvl_d, prev_q, diff, hit;
  logic [CW-1:0] cnt_q, cnt_d;
  assign diff  = sync_q[1] != lvl_q;
  assign hit   = diff && cnt_q == CW'(DEBOUNCE_CYCLES - 1);
  assign cnt_d = diff && !hit ? cnt_q + 1'b1 : '0;
  assign lvl_d = hit ? sync_q[1] : lvl_q;
  assign press = lvl_q & ~prev_q;
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '0;
      lvl_q  <= 1'b0;
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
      lvl_q  <= lvl_d;
      prev_q <= lvl_q;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/ped_crossing_ctrl.sv
// ped_crossing_ctrl: pedestrian head and request conditioning beside traffic_light
// Ports: clk, reset (sync, active-low), btn_raw, red/yellow/green (vehicle lamps in),
//   ped_button (request to traffic_light), walk, dont_walk, req_pending, fault (sticky).
// Macro PED_COUNTDOWN_EN adds output countdown (remaining walk+flash cycles).
module ped_crossing_ctrl
  import ped_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WALK_CYCLES     = 40,
  parameter int FLASH_CYCLES    = 20,
  parameter int FLASH_HALF      = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  input  logic red,
  input  logic yellow,
  input  logic green,
  output logic ped_button,
  output logic walk,
  output logic dont_walk,
  output logic req_pending,
  output logic fault
`ifdef PED_COUNTDOWN_EN
  ,
  output logic [$clog2(WALK_CYCLES+FLASH_CYCLES+1)-1:0] countdown
`endif
);
  localparam int TW = $clog2(WALK_CYCLES + FLASH_CYCLES + 1);
  localparam int HW = $clog2(FLASH_HALF + 1);
  ped_state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [HW-1:0] hc_q, hc_d;
  logic fl_q, fl_d, req_q, req_d, red_prev_q, off_q, press, red_on, red_rise, bad, half_end;
  logic [2:0] lamp_q;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
    .clk(clk),
    .reset(reset),
    .btn_raw(btn_raw),
    .press(press)
  );
  assign red_on   = |(lamp_q & LAMP_R);
  assign red_rise = lamp_q == LAMP_R && !red_prev_q;
  // off_q remembers the previous lamp_q was dark, so a single dark cycle (e.g. straight after reset) is tolerated.
  assign bad      = !legal_lamp(lamp_q) || (lamp_q == 3'b000 && off_q);
  assign half_end = hc_q == HW'(FLASH_HALF - 1);
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    hc_d    = hc_q;
    fl_d    = fl_q;
    req_d   = req_q | press;
    case (state_q)
      IDLE: state_d = press || req_q ? WAIT : IDLE;
      WAIT: if (red_rise) begin
        state_d = WALK;
        req_d   = 1'b0;
        timer_d = TW'(WALK_CYCLES - 1);
      end
      WALK: begin
        timer_d = timer_q - 1'b1;
        if (!red_on) state_d = IDLE;
        else if (timer_q == '0) begin
          state_d = FLASH;
          timer_d = TW'(FLASH_CYCLES - 1);
          hc_d    = '0;
          fl_d    = 1'b0;
        end
      end
      FLASH: begin
        timer_d = timer_q - 1'b1;
        hc_d    = half_end ? '0 : hc_q + 1'b1;
        fl_d    = half_end ? ~fl_q : fl_q;
        if (!red_on) state_d = IDLE;
        else if (timer_q == '0) state_d = req_d ? WAIT : IDLE;
      end
      default: req_d = 1'b0;
    endcase
    if (bad) begin
      state_d = FAULT;
      req_d   = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      hc_q       <= '0;
      fl_q       <= 1'b0;
      req_q      <= 1'b0;
      lamp_q     <= 3'b000;
      red_prev_q <= 1'b0;
      off_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      hc_q       <= hc_d;
      fl_q       <= fl_d;
      req_q      <= req_d;
      lamp_q     <= {red, yellow, green};
      red_prev_q <= red_on;
      off_q      <= lamp_q == 3'b000;
    end
  end
  assign ped_button  = state_q == WAIT;
  assign walk        = state_q == WALK;
  assign dont_walk   = state_q == FLASH ? fl_q : state_q != WALK;
  assign req_pending = req_q;
  assign fault       = state_q == FAULT;
`ifdef PED_COUNTDOWN_EN
  assign countdown = state_q == WALK ? timer_q + TW'(FLASH_CYCLES) : state_q == FLASH ? timer_q : '0;
`endif
endmodule

// File: doc/ped_crossing_ctrl.md
Name: ped_crossing_ctrl

Overview:
- Pedestrian-side companion to traffic_light: conditions the raw crosswalk push-button and drives the controller's ped_button input.
- Observes the controller's red/yellow/green lamps and drives the WALK / DONT_WALK pedestrian head.
- Flags illegal lamp combinations from the vehicle controller.
- Sits beside traffic_light in the top level on the same clk.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable cycles needed to accept a button level change (>=1)
WALK_CYCLES, 40, cycles walk is held steady (>=1)
FLASH_CYCLES, 20, cycles of flashing dont_walk after walk (>=2)
FLASH_HALF, 2, half-period of the dont_walk flash, in cycles (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
btn_raw  in  1  asynchronous, bouncy pedestrian button
red  in  1  vehicle red lamp from traffic_light
yellow  in  1  vehicle yellow lamp
green  in  1  vehicle green lamp
ped_button  out  1  request level to traffic_light
walk  out  1  WALK lamp
dont_walk  out  1  DONT_WALK lamp (steady or flashing)
req_pending  out  1  "request registered" indicator lamp
fault  out  1  sticky illegal-lamp flag

Behaviour:
- Reset: reset is synchronous, active-low.
  - While reset==0 at a clk edge: ped_button=0, walk=0, dont_walk=1, req_pending=0, fault=0, state=IDLE, all counters 0.
  - Debounced button level resets to 0; lamp sample registers reset to 000.
  - Reset mid-WALK/FLASH aborts immediately.
- Button path:
  - 2-flop synchronizer on btn_raw.
  - Debounce counter increments while the synchronized value != the debounced level, and clears otherwise.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the new value and the counter clears.
  - A press = rising edge of the debounced level; one press per physical press.
  - Latency: req_pending rises 2+DEBOUNCE_CYCLES+1 cycles after a clean btn_raw rise.
  - A glitch shorter than DEBOUNCE_CYCLES produces no press.
- Lamp path:
  - red/yellow/green are registered once (lamp_q). All decisions use lamp_q.
  - red_rise = lamp_q red 0->1 with yellow=0 and green=0.
- FSM states: IDLE, WAIT, WALK, FLASH, FAULT.
  - IDLE: dont_walk=1. A press moves to WAIT and sets req_pending.
  - WAIT: dont_walk=1, ped_button=1.
    - red_rise moves to WALK, clears req_pending, loads timer=WALK_CYCLES-1.
    - A red already on at press time does not qualify; the next rising edge is required.
  - WALK: walk=1, dont_walk=0, timer decrements each cycle.
    - When timer==0, move to FLASH and load timer=FLASH_CYCLES-1.
    - walk is high for exactly WALK_CYCLES cycles.
  - FLASH: walk=0.
    - dont_walk starts at 0 and toggles every FLASH_HALF cycles.
    - When timer==0, move to IDLE with dont_walk=1.
  - Presses during WALK/FLASH set req_pending. On return to IDLE with req_pending=1, move directly to WAIT.
  - Early red drop (lamp_q red==0) in WALK or FLASH aborts to IDLE next cycle: walk=0, dont_walk=1.
- Fault detection:
  - Fault condition: lamp_q has more than one lamp on, or all-off for more than 1 consecutive cycle.
  - Enters FAULT; fault=1 sticky until reset.
  - In FAULT: walk=0, dont_walk=1, ped_button=0, req_pending=0. Presses are ignored.
  - Fault has priority over all other transitions in the same cycle.
  - The first cycle after reset (lamp_q=000) is exempt.
- Outputs are registered (state-decoded from registers), with no combinational path from inputs.

Optional Feature:
- Macro: PED_COUNTDOWN_EN.
- Defined:
  - Adds output countdown, width $clog2(WALK_CYCLES+FLASH_CYCLES+1).
  - Shows remaining walk+flash cycles: WALK_CYCLES+FLASH_CYCLES-1 on the first WALK cycle, decrementing to 0 on the last FLASH cycle.
  - 0 in all other states and on reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package ped_pkg holds:
  - ped_state_t enum (IDLE, WAIT, WALK, FLASH, FAULT);
  - the lamp encoding constants LAMP_R=3'b100, LAMP_Y=3'b010, LAMP_G=3'b001;
  - a function legal_lamp(3-bit).
- Sub-module btn_debounce (synchronizer + debounce + rising-edge pulse, param DEBOUNCE_CYCLES) is natural. It is reused for other panel buttons.

Test Plan:
- Reset: hold reset=0 for 5 cycles with btn_raw toggling -> walk=0, dont_walk=1, ped_button=0, fault=0 throughout and 1 cycle after release.
- Bounce reject: btn_raw pulses of 1-3 cycles -> req_pending stays 0. A 10-cycle press -> req_pending=1 exactly 7 cycles after the rise, and ped_button=1.
- Full crossing: press, green→yellow→red (red held 100 cycles) -> walk=1 from 2 cycles after red rises for exactly 40 cycles; dont_walk toggles every 2 cycles for 20 cycles; then IDLE with dont_walk=1 and ped_button=0.
- Early red drop: red falls 10 cycles into WALK -> walk=0, dont_walk=1 two cycles later; state IDLE.
- Fault: drive red=1, green=1 together -> fault=1 two cycles later, sticky. Later presses are ignored; cleared only by reset=0.
- Re-request: press during WALK -> req_pending=1; after FLASH ends, ped_button reasserts the next cycle; with PED_COUNTDOWN_EN, countdown = 59 on the first WALK cycle.
